// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the 32-bit core.
// Fetches over a req/ack instruction port into the instruction register,
// then walks each instruction through DECODE/EXEC/MEM/WB, driving the
// ALU controls, data-memory strobes, register write enable and PC update.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] INST,
  output logic [2:0]  alu_op,
  output logic        ALUSrc,
  input  logic        alu_zero,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic        wb_sel,
  output logic [31:0] pc,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        illegal_q, illegal_d;

  // Instruction fields
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [5:0] imm;
  assign opcode = inst_q[31:26];
  assign funct  = inst_q[5:0];
  assign imm    = inst_q[5:0];

  // Instruction classification and the ALU controls that EXEC and WB share
  logic       is_rtype, is_addi, is_lw, is_sw, is_beq, is_halt, is_illegal;
  logic       r_funct_ok;
  logic [2:0] r_alu_op;
  logic [2:0] insn_alu_op;
  logic       insn_alusrc;

  // Decode opcode/funct into instruction class and ALU controls
  always_comb begin
    r_funct_ok = 1'b1;
    r_alu_op   = ALU_ADD;
    case (funct)
      6'h20:   r_alu_op = ALU_ADD;
      6'h22:   r_alu_op = ALU_SUB;
      6'h24:   r_alu_op = ALU_AND;
      6'h25:   r_alu_op = ALU_OR;
      6'h2A:   r_alu_op = ALU_SLT;
      default: r_funct_ok = 1'b0;
    endcase

    is_rtype   = (opcode == 6'h00) && r_funct_ok;
    is_addi    = (opcode == 6'h08);
    is_lw      = (opcode == 6'h23);
    is_sw      = (opcode == 6'h2B);
    is_beq     = (opcode == 6'h04);
    is_halt    = (opcode == 6'h3F);
    is_illegal = !(is_rtype || is_addi || is_lw || is_sw || is_beq || is_halt);

    if (is_rtype) begin
      insn_alu_op = r_alu_op;
    end else if (is_beq) begin
      insn_alu_op = ALU_SUB;
    end else begin
      insn_alu_op = ALU_ADD;
    end
    insn_alusrc = is_addi || is_lw || is_sw;
  end

  // Next-state logic and state-dependent strobes
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    alu_op    = ALU_ADD;
    ALUSrc    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          inst_d  = imem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_illegal) begin
          illegal_d = 1'b1;
          state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op = insn_alu_op;
        ALUSrc = insn_alusrc;
        if (is_rtype || is_addi) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          // BEQ: forward-only branch; pc already points at the next instruction
          if (alu_zero) begin
            pc_d = pc_q + {24'b0, imm, 2'b00};
          end
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ack) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        // Hold the EXEC ALU controls so the write-back value stays stable
        alu_op  = insn_alu_op;
        ALUSrc  = insn_alusrc;
        reg_we  = 1'b1;
        wb_sel  = is_lw;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State, PC, instruction register and sticky illegal flag
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign INST      = inst_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. A second instance with
// ILLEGAL_HALT=0 and RESET_PC=0xFFFF_FFFC shares all inputs; it runs in
// lockstep four bytes behind the main instance, covering PC wrap and the
// skip-on-illegal behaviour.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        alu_zero;
  logic        dmem_ack;

  logic        imem_req, ALUSrc, dmem_req, dmem_we, reg_we, wb_sel, halted, illegal;
  logic [31:0] imem_addr, INST, pc;
  logic [2:0]  alu_op;

  logic        s_imem_req, s_ALUSrc, s_dmem_req, s_dmem_we, s_reg_we, s_wb_sel, s_halted, s_illegal;
  logic [31:0] s_imem_addr, s_INST, s_pc;
  logic [2:0]  s_alu_op;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  multicycle_ctrl #(.RESET_PC(32'h0000_0000), .ILLEGAL_HALT(1'b1)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .INST(INST), .alu_op(alu_op), .ALUSrc(ALUSrc), .alu_zero(alu_zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_we(reg_we), .wb_sel(wb_sel), .pc(pc), .halted(halted), .illegal(illegal)
  );

  multicycle_ctrl #(.RESET_PC(32'hFFFF_FFFC), .ILLEGAL_HALT(1'b0)) u_dut_skip (
    .CLK(CLK), .RST_N(RST_N),
    .imem_req(s_imem_req), .imem_addr(s_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .INST(s_INST), .alu_op(s_alu_op), .ALUSrc(s_ALUSrc), .alu_zero(alu_zero),
    .dmem_req(s_dmem_req), .dmem_we(s_dmem_we), .dmem_ack(dmem_ack),
    .reg_we(s_reg_we), .wb_sel(s_wb_sel), .pc(s_pc), .halted(s_halted), .illegal(s_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Run one instruction from its FETCH (ack immediate) until the next fetch request
  task automatic run_instr(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                           input int dwait, input logic zero, input int exp_cycles,
                           input logic [31:0] exp_next, input int exp_we, input int exp_dmem,
                           input logic [2:0] exp_op, input logic exp_src, input logic exp_sel,
                           input logic exp_dwe);
    int n, we_cnt, dm_cnt;
    logic [2:0] op;
    logic src;
    check({tag, ".req"}, imem_req, 1'b1);
    check({tag, ".addr"}, imem_addr, addr);
    imem_rdata = instr;
    imem_ack   = 1'b1;
    alu_zero   = zero;
    step();
    imem_ack = 1'b0;
    check({tag, ".inst"}, INST, instr);
    n = 1; we_cnt = 0; dm_cnt = 0; op = 3'b0; src = 1'b0;
    while (!imem_req && n < 40) begin
      if (n == 2) begin
        op  = alu_op;
        src = ALUSrc;
      end
      if (dmem_req) begin
        dm_cnt++;
        check({tag, ".dmem_we"}, dmem_we, exp_dwe);
        dmem_ack = (dm_cnt > dwait);
      end
      if (reg_we) begin
        we_cnt++;
        check({tag, ".wb_sel"}, wb_sel, exp_sel);
        check({tag, ".wb_alu_op"}, alu_op, exp_op);
        check({tag, ".wb_alusrc"}, ALUSrc, exp_src);
      end
      step();
      dmem_ack = 1'b0;
      n++;
    end
    check({tag, ".cycles"}, n, exp_cycles);
    check({tag, ".alu_op"}, op, exp_op);
    check({tag, ".alusrc"}, src, exp_src);
    check({tag, ".reg_we_cnt"}, we_cnt, exp_we);
    check({tag, ".dmem_cnt"}, dm_cnt, exp_dmem);
    check({tag, ".next_pc"}, pc, exp_next);
    check({tag, ".next_addr"}, imem_addr, exp_next);
    check({tag, ".skip_pc"}, s_pc, exp_next - 32'd4);
    $display("instr %s: %0d cycles, next fetch 0x%08h", tag, n, imem_addr);
  endtask

  initial begin
    RST_N = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; alu_zero = 1'b0; dmem_ack = 1'b0;
    step();
    step();
    check("rst.pc", pc, 32'h0);
    check("rst.inst", INST, 32'h0);
    check("rst.illegal", illegal, 1'b0);
    check("rst.halted", halted, 1'b0);
    check("rst.reg_we", reg_we, 1'b0);
    check("rst.dmem_req", dmem_req, 1'b0);
    check("rst.skip_pc", s_pc, 32'hFFFF_FFFC);
    RST_N = 1'b1;
    $display("reset applied");

    //         tag       addr        instr        dw z cyc next        we dm op      src sel dwe
    run_instr("add",    32'h00, 32'h00221820, 0, 0, 4, 32'h04,       1, 0, 3'b000, 0, 0, 0);
    run_instr("lw",     32'h04, 32'h8C000004, 3, 0, 8, 32'h08,       1, 4, 3'b000, 1, 1, 0);
    run_instr("addi",   32'h08, 32'h20000005, 0, 0, 4, 32'h0C,       1, 0, 3'b000, 1, 0, 0);
    run_instr("slt",    32'h0C, 32'h0022182A, 0, 0, 4, 32'h10,       1, 0, 3'b100, 0, 0, 0);
    run_instr("beq_t",  32'h10, 32'h10000003, 0, 1, 3, 32'h20,       0, 0, 3'b001, 0, 0, 0);
    run_instr("beq_nt", 32'h20, 32'h10000003, 0, 0, 3, 32'h24,       0, 0, 3'b001, 0, 0, 0);
    run_instr("sub",    32'h24, 32'h00221822, 0, 0, 4, 32'h28,       1, 0, 3'b001, 0, 0, 0);
    run_instr("and",    32'h28, 32'h00221824, 0, 0, 4, 32'h2C,       1, 0, 3'b010, 0, 0, 0);
    run_instr("or",     32'h2C, 32'h00221825, 0, 0, 4, 32'h30,       1, 0, 3'b011, 0, 0, 0);
    run_instr("sw",     32'h30, 32'hAC000002, 2, 0, 6, 32'h34,       0, 3, 3'b000, 1, 0, 1);

    // SW interrupted by reset while in MEM
    check("swrst.addr", imem_addr, 32'h34);
    imem_rdata = 32'hAC000002; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    step();
    check("swrst.dmem_req", dmem_req, 1'b1);
    check("swrst.dmem_we", dmem_we, 1'b1);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    check("swrst.dmem_off", dmem_req, 1'b0);
    check("swrst.reg_we", reg_we, 1'b0);
    check("swrst.req", imem_req, 1'b1);
    check("swrst.pc", pc, 32'h0);
    check("swrst.addr0", imem_addr, 32'h0);
    $display("sw interrupted by reset, refetch at 0x%08h", imem_addr);

    // Illegal opcode 0x11: main halts, skip instance continues at pc+4
    imem_rdata = 32'h44000000; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("ill.halted_decode", halted, 1'b0);
    step();
    check("ill.halted", halted, 1'b1);
    check("ill.illegal", illegal, 1'b1);
    check("ill.req", imem_req, 1'b0);
    check("ill.skip_illegal", s_illegal, 1'b1);
    check("ill.skip_halted", s_halted, 1'b0);
    check("ill.skip_req", s_imem_req, 1'b1);
    check("ill.skip_addr", s_imem_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ill.no_req", imem_req, 1'b0);
    end
    $display("illegal opcode: main halted=%0d, skip fetching 0x%08h", halted, s_imem_addr);

    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    check("rst2.illegal", illegal, 1'b0);
    check("rst2.halted", halted, 1'b0);

    // HALT opcode 0x3F
    imem_rdata = 32'hFC000000; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    check("halt.halted", halted, 1'b1);
    check("halt.illegal", illegal, 1'b0);
    check("halt.skip_halted", s_halted, 1'b1);
    // An ack while halted must be ignored
    imem_rdata = 32'h00221820; imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt.no_req", imem_req, 1'b0);
    end
    imem_ack = 1'b0;
    check("halt.pc", pc, 32'h4);
    check("halt.inst", INST, 32'hFC000000);
    check("halt.still", halted, 1'b1);
    $display("halt opcode: halted=%0d pc=0x%08h", halted, pc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the 32-bit CPU core. It fetches instructions over a req/ack instruction-memory handshake and holds the current instruction in an instruction register that feeds the instruction decoder. It then steps each instruction through DECODE/EXEC/MEM/WB states, driving ALU operation, ALU source select, data-memory strobes, register write enable and PC update. It sits between the memories and the decoder/ALU/register-file datapath.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ILLEGAL_HALT, 1, 1: an illegal opcode/funct enters HALT; 0: it is skipped (back to FETCH)

Ports:
- CLK  in  1  single clock; all state changes on rising edge
- RST_N  in  1  reset, synchronous, active-low
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= PC)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- INST  out  32  instruction register, to decoder
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
- ALUSrc  out  1  0: SrcB from register rt; 1: zero-extended INST[5:0]
- alu_zero  in  1  ALU result == 0
- dmem_req  out  1  data-memory access request
- dmem_we  out  1  1 store, 0 load (valid with dmem_req)
- dmem_ack  in  1  data access complete
- reg_we  out  1  register-file write strobe (one cycle)
- wb_sel  out  1  0: write ALU result; 1: write load data
- pc  out  32  current PC
- halted  out  1  state == HALT
- illegal  out  1  sticky; set on an illegal instruction

## Operation

- Reset (RST_N low at an edge): state=FETCH, pc=RESET_PC, INST=0, illegal=0. All strobes are combinational from state and INST and are 0 outside their states.
- Instruction set:
  - opcode 0, R-type, with funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - opcode 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x3F HALT.
  - Any other opcode, or any other funct with opcode 0, is illegal.
- FETCH: imem_req=1, imem_addr=pc. Stay until imem_ack=1. On the ack edge: INST<=imem_rdata, pc<=pc+4, go to DECODE.
- DECODE: one cycle, no strobes.
  - HALT goes to HALT.
  - An illegal instruction sets illegal, then goes to HALT if ILLEGAL_HALT=1, else to FETCH.
  - All others go to EXEC.
- EXEC: one cycle.
  - R-type: alu_op from funct, ALUSrc=0, then WB.
  - ADDI/LW/SW: alu_op=ADD, ALUSrc=1. ADDI goes to WB; LW/SW go to MEM.
  - BEQ: alu_op=SUB, ALUSrc=0. If alu_zero, pc<=pc+({26'b0,INST[5:0]}<<2). Then FETCH.
- MEM: dmem_req=1, dmem_we=1 for SW. Hold until dmem_ack=1. Then LW goes to WB, SW goes to FETCH.
- WB: one cycle, reg_we=1.
  - wb_sel=1 for LW, 0 otherwise.
  - alu_op/ALUSrc keep their EXEC values so the ALU result stays stable.
  - Then FETCH.
- HALT: absorbing; all strobes 0; exits only by reset.
- Arithmetic: pc wraps modulo 2^32. The branch offset is unsigned (forward only), consistent with the 6-bit zero-extended immediate.

## Timing

- Latency with ack in the same cycle as req:
  - R-type/ADDI: 4 cycles
  - LW: 5
  - SW: 4
  - BEQ: 3
  - HALT: 2, then halted=1
- Each wait cycle in FETCH/MEM adds one cycle.
- req stays high until ack is sampled. Requests never drop before ack except on reset.
- An ack received outside FETCH/MEM is ignored.
- Reset mid-instruction: the next edge goes to FETCH with pc=RESET_PC. dmem_req/reg_we are 0 from that cycle on; a partially executed instruction has no architectural effect.
- halted and illegal are registered and valid the cycle after the DECODE edge.

## Test plan

- Reset then ADD (0x00221820), imem_ack immediate -> imem_req high 1 cycle at addr 0; INST=0x00221820; alu_op=000, ALUSrc=0; reg_we=1, wb_sel=0 in cycle 4; pc=4; second fetch at addr 4 in cycle 5.
- LW (opcode 0x23, imm 4) with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; ALUSrc=1, alu_op=ADD; reg_we=1, wb_sel=1 once; 8 cycles total.
- BEQ at pc=0x10, imm=3:
  - alu_zero=1 -> next fetch at 0x14+12=0x20.
  - alu_zero=0 -> next fetch at 0x14.
  - reg_we never asserted.
- SW, with RST_N pulled low during MEM -> the next cycle has dmem_req=0, state FETCH, pc=RESET_PC; the fetch restarts at RESET_PC.
- Opcode 0x3F, and illegal opcode 0x11 with ILLEGAL_HALT=1 -> halted=1, no further imem_req. With ILLEGAL_HALT=0, opcode 0x11 -> illegal=1 and the fetch at pc+4 continues.
- pc=0xFFFF_FFFC, R-type -> pc wraps to 0x0000_0000.
